// File: rtl/key_debounce.sv
// key_debounce: per-key push-button debouncer for the elevator panel keys.
// Each key runs a two-flop synchronizer followed by a 4-state debounce FSM
// with an 8-bit saturating stability counter. A press is accepted after
// DEB_CYCLES consecutive stable samples, and the same holds for a release.
//
// Ports:
//   clk10000hz  in   1        single clock, all flops on its rising edge
//   reset       in   1        synchronous, active-high reset
//   key_in      in   N_KEYS   raw asynchronous key levels, 1 = pressed
//   key_level   out  N_KEYS   debounced stable level per key
//   key_pulse   out  N_KEYS   one-cycle press strobe per key
//   key_any     out  1        OR of key_level
//   key_release out  N_KEYS   one-cycle release strobe per key
//                             (present only when KEY_RELEASE_PULSE_EN is defined)
//
// Optional feature macro: KEY_RELEASE_PULSE_EN.
module key_debounce #(
    parameter int unsigned N_KEYS     = 10,
    parameter int unsigned DEB_CYCLES = 200
) (
    input  logic              clk10000hz,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_pulse,
    output logic              key_any
`ifdef KEY_RELEASE_PULSE_EN
    ,
    output logic [N_KEYS-1:0] key_release
`endif
);

    localparam int unsigned CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    logic [N_KEYS-1:0] r_s1;
    logic [N_KEYS-1:0] r_s2;
    logic [N_KEYS-1:0] w_level_nxt;
    logic [N_KEYS-1:0] w_pulse_nxt;
    logic [N_KEYS-1:0] w_release_nxt;
    logic [N_KEYS-1:0] r_level;
    logic [N_KEYS-1:0] r_pulse;
    logic              r_any;

    // Two-flop synchronizer; only r_s2 feeds the FSMs
    always_ff @(posedge clk10000hz) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= key_in;
            r_s2 <= r_s1;
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] w_cnt_inc;

        // Saturating increment so a stuck counter can never wrap back to 0
        assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

        // State and counter register
        always_ff @(posedge clk10000hz) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // Next state; counter defaults to 0 so every WAIT entry starts clean
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = '0;
            case (r_state)
                ST_IDLE: begin
                    if (r_s2[g]) w_state_nxt = ST_PRESS_WAIT;
                end
                ST_PRESS_WAIT: begin
                    if (!r_s2[g])              w_state_nxt = ST_IDLE;
                    else if (r_cnt == CNT_LAST) w_state_nxt = ST_PRESSED;
                    else                        w_cnt_nxt   = w_cnt_inc;
                end
                ST_PRESSED: begin
                    if (!r_s2[g]) w_state_nxt = ST_RELEASE_WAIT;
                end
                ST_RELEASE_WAIT: begin
                    if (r_s2[g])                w_state_nxt = ST_PRESSED;
                    else if (r_cnt == CNT_LAST) w_state_nxt = ST_IDLE;
                    else                        w_cnt_nxt   = w_cnt_inc;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        // Output decode from the transition; registered below so level and
        // strobes all change on the accepting edge
        always_comb begin
            w_level_nxt[g]   = (w_state_nxt == ST_PRESSED) ||
                               (w_state_nxt == ST_RELEASE_WAIT);
            w_pulse_nxt[g]   = (r_state == ST_PRESS_WAIT) &&
                               (w_state_nxt == ST_PRESSED);
            w_release_nxt[g] = (r_state == ST_RELEASE_WAIT) &&
                               (w_state_nxt == ST_IDLE);
        end
    end

    // Output registers
    always_ff @(posedge clk10000hz) begin
        if (reset) begin
            r_level <= '0;
            r_pulse <= '0;
            r_any   <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
            r_any   <= |w_level_nxt;
        end
    end

    assign key_level = r_level;
    assign key_pulse = r_pulse;
    assign key_any   = r_any;

`ifdef KEY_RELEASE_PULSE_EN
    logic [N_KEYS-1:0] r_release;

    // Release strobe register
    always_ff @(posedge clk10000hz) begin
        if (reset) r_release <= '0;
        else       r_release <= w_release_nxt;
    end

    assign key_release = r_release;
`else
    logic w_release_unused;
    assign w_release_unused = ^w_release_nxt;
`endif

endmodule
